// File: rtl/lfsr_chk_if.sv
// Bit-stream and status bundle for the lfsr_chk PRBS checker.
// master: the side that feeds received bits and reads status.
// slave : the checker itself.
interface lfsr_chk_if #(
  parameter int CNT_W = 16
);
  logic             bit_in;
  logic             bit_vld;
  logic             clr;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output bit_in, bit_vld, clr,
    input  locked, err_pulse, err_cnt, bit_cnt
  );

  modport slave (
    input  bit_in, bit_vld, clr,
    output locked, err_pulse, err_cnt, bit_cnt
  );
endinterface

// File: rtl/lfsr_chk.sv
// lfsr_chk: self-synchronising serial checker for the x^16+x^5+x^3+x^2+1
// PRBS. Fills a 16-bit history from the line, verifies SYNC_LEN
// predictions, then locks and counts mismatches against its own recurrence.
// Optional window-based loss of lock is compiled in with LFSR_CHK_LOSS_EN.
module lfsr_chk #(
  parameter int SYNC_LEN = 32,
  parameter int WIN      = 64,
  parameter int LOSS_THR = 8,
  parameter int CNT_W    = 16
) (
  input  logic     clk,
  input  logic     _rst,
  lfsr_chk_if.slave bus
);

  localparam int MW = $clog2(SYNC_LEN + 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Parameter sanity: every parameter must describe a non-empty quantity.
  if (SYNC_LEN < 1 || WIN < 1 || LOSS_THR < 1) begin : g_bad_cfg
    $error("lfsr_chk: SYNC_LEN, WIN and LOSS_THR must be >= 1");
  end

  state_t           state, state_n;
  logic [15:0]      h, h_n;
  logic [4:0]       fill, fill_n;
  logic [MW-1:0]    match, match_n;
  logic [CNT_W-1:0] err_q, err_n;
  logic [CNT_W-1:0] bit_q, bit_n;
  logic             pulse_q, pulse_n;
  logic             locked_q, locked_n;
  logic             p;
  logic             miss;

`ifdef LFSR_CHK_LOSS_EN
  localparam int WPW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int EW  = $clog2(LOSS_THR + 1);

  logic [WPW-1:0] wpos, wpos_n;
  logic [EW-1:0]  werr, werr_n;
`endif

  // Taps for s[n] = s[n-16]^s[n-14]^s[n-13]^s[n-11] with h[0] newest.
  assign p    = h[15] ^ h[13] ^ h[12] ^ h[10];
  assign miss = bus.bit_in ^ p;

  // Next-state, history, sync counters and statistics.
  always_comb begin
    state_n = state;
    h_n     = h;
    fill_n  = fill;
    match_n = match;
    err_n   = err_q;
    bit_n   = bit_q;
    pulse_n = 1'b0;
`ifdef LFSR_CHK_LOSS_EN
    wpos_n  = wpos;
    werr_n  = werr;
`endif

    if (bus.bit_vld) begin
      case (state)
        FILL: begin
          h_n = {h[14:0], bus.bit_in};
          if (fill != 5'd16) fill_n = fill + 5'd1;
          // All-zero history would predict zeros forever; refuse to sync on it.
          if (fill_n >= 5'd16 && h_n != 16'h0000) begin
            state_n = VERIFY;
            match_n = '0;
          end
        end

        VERIFY: begin
          if (miss) begin
            // Seed was wrong (or line error): start over from scratch.
            h_n     = '0;
            fill_n  = '0;
            match_n = '0;
            state_n = FILL;
          end else begin
            h_n = {h[14:0], bus.bit_in};
            if (match == MW'(SYNC_LEN - 1)) begin
              state_n = LOCKED;
              match_n = '0;
`ifdef LFSR_CHK_LOSS_EN
              wpos_n  = '0;
              werr_n  = '0;
`endif
            end else begin
              match_n = match + MW'(1);
            end
          end
        end

        LOCKED: begin
          // Feed back the prediction so one bad line bit is one error only.
          h_n = {h[14:0], p};
          if (bit_q != '1) bit_n = bit_q + CNT_W'(1);
          if (miss) begin
            pulse_n = 1'b1;
            if (err_q != '1) err_n = err_q + CNT_W'(1);
          end
`ifdef LFSR_CHK_LOSS_EN
          if (miss && (int'(werr) + 1 >= LOSS_THR)) begin
            state_n = FILL;
            h_n     = '0;
            fill_n  = '0;
            match_n = '0;
            wpos_n  = '0;
            werr_n  = '0;
          end else if (int'(wpos) == WIN - 1) begin
            wpos_n = '0;
            werr_n = '0;
          end else begin
            wpos_n = wpos + WPW'(1);
            werr_n = werr + EW'(miss);
          end
`endif
        end

        default: begin
          state_n = FILL;
          h_n     = '0;
          fill_n  = '0;
          match_n = '0;
        end
      endcase
    end

    // Clear wins over any same-cycle increment; FSM is untouched.
    if (bus.clr) begin
      err_n = '0;
      bit_n = '0;
    end

    locked_n = (state_n == LOCKED);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state    <= FILL;
      h        <= '0;
      fill     <= '0;
      match    <= '0;
      err_q    <= '0;
      bit_q    <= '0;
      pulse_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state    <= state_n;
      h        <= h_n;
      fill     <= fill_n;
      match    <= match_n;
      err_q    <= err_n;
      bit_q    <= bit_n;
      pulse_q  <= pulse_n;
      locked_q <= locked_n;
    end
  end

`ifdef LFSR_CHK_LOSS_EN
  // Loss-detection window position and error tally.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      wpos <= '0;
      werr <= '0;
    end else begin
      wpos <= wpos_n;
      werr <= werr_n;
    end
  end
`endif

  assign bus.locked    = locked_q;
  assign bus.err_pulse = pulse_q;
  assign bus.err_cnt   = err_q;
  assign bus.bit_cnt   = bit_q;

endmodule

// File: tb/tb_lfsr_chk.sv
// Directed bench for lfsr_chk: reset, clean lock, single error, zero
// stream, VERIFY restart, window loss, gaps/clr/async reset.
module tb_lfsr_chk;

  logic clk  = 1'b0;
  logic _rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   pulse_seen;
  int   lock_seen;
  int   seed_cnt;
  logic [15:0] gh;
  logic b;

  lfsr_chk_if #(.CNT_W(16)) bus ();

  lfsr_chk #(
    .SYNC_LEN(32), .WIN(64), .LOSS_THR(8), .CNT_W(16)
  ) dut (
    .clk (clk),
    ._rst(_rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference source: 15 zeros then a one (history 16'h0001), then the recurrence.
  task automatic gen(output logic nb);
    if (seed_cnt < 16) begin
      nb = (seed_cnt == 15);
      seed_cnt++;
    end else begin
      nb = gh[15] ^ gh[13] ^ gh[12] ^ gh[10];
    end
    gh = {gh[14:0], nb};
  endtask

  task automatic step(input logic sb, input logic v, input logic c);
    bus.bit_in  = sb;
    bus.bit_vld = v;
    bus.clr     = c;
    @(posedge clk);
    #1;
    bus.bit_vld = 1'b0;
    bus.clr     = 1'b0;
    if (bus.err_pulse) pulse_seen++;
    if (bus.locked)    lock_seen++;
  endtask

  task automatic clean(input int n);
    logic cb;
    for (int i = 0; i < n; i++) begin
      gen(cb);
      step(cb, 1'b1, 1'b0);
    end
  endtask

  task automatic bad();
    logic cb;
    gen(cb);
    step(~cb, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    _rst = 1'b0;
    gh = '0;
    seed_cnt = 0;
    @(posedge clk);
    #1;
    _rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.bit_in = 1'b0; bus.bit_vld = 1'b0; bus.clr = 1'b0;
    gh = '0; seed_cnt = 0;

    // Reset values
    #12;
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_pulse",  32'(bus.err_pulse), 0);
    chk("rst_err",    32'(bus.err_cnt), 0);
    chk("rst_bit",    32'(bus.bit_cnt), 0);
    do_reset();

    // Zero stream never locks
    lock_seen = 0;
    for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 1'b0);
    chk("zero_never_locked", 32'(lock_seen), 0);
    chk("zero_bit_cnt", 32'(bus.bit_cnt), 0);

    // Clean stream from reset: lock after valid bit 48
    do_reset();
    clean(47);
    chk("lock_not_at_47", 32'(bus.locked), 0);
    clean(1);
    chk("lock_at_48", 32'(bus.locked), 1);
    chk("lock_err0", 32'(bus.err_cnt), 0);
    chk("lock_bit0", 32'(bus.bit_cnt), 0);
    clean(10);
    chk("bit_cnt_10", 32'(bus.bit_cnt), 10);

    // Single error at compare 100
    pulse_seen = 0;
    clean(89);
    chk("bit_cnt_99", 32'(bus.bit_cnt), 99);
    chk("no_pulse_pre", 32'(pulse_seen), 0);
    bad();
    chk("err1_pulse", 32'(bus.err_pulse), 1);
    chk("err1_cnt", 32'(bus.err_cnt), 1);
    chk("err1_bit", 32'(bus.bit_cnt), 100);
    clean(1);
    chk("err1_pulse_drop", 32'(bus.err_pulse), 0);
    pulse_seen = 0;
    clean(499);
    chk("post_err_no_pulse", 32'(pulse_seen), 0);
    chk("post_err_cnt", 32'(bus.err_cnt), 1);
    chk("post_bit_cnt", 32'(bus.bit_cnt), 600);
    chk("post_locked", 32'(bus.locked), 1);

    // Error during VERIFY at compare 10 restarts fill
    do_reset();
    clean(16 + 9);
    bad();
    chk("verify_err_unlocked", 32'(bus.locked), 0);
    chk("verify_err_no_cnt", 32'(bus.err_cnt), 0);
    chk("verify_err_no_pulse", 32'(bus.err_pulse), 0);
    clean(47);
    chk("relock_not_47", 32'(bus.locked), 0);
    clean(1);
    chk("relock_at_48", 32'(bus.locked), 1);

    // 8 errors inside one 64-bit window
    for (int i = 0; i < 7; i++) begin
      bad();
      clean(1);
    end
    chk("win7_locked", 32'(bus.locked), 1);
    chk("win7_err", 32'(bus.err_cnt), 7);
    bad();
    chk("win8_err", 32'(bus.err_cnt), 8);
    chk("win8_pulse", 32'(bus.err_pulse), 1);
`ifdef LFSR_CHK_LOSS_EN
    chk("win8_locked", 32'(bus.locked), 0);
`else
    chk("win8_locked", 32'(bus.locked), 1);
`endif

    // Gaps, clr with error, async reset
    do_reset();
    clean(48);
    chk("gap_pre_locked", 32'(bus.locked), 1);
    pulse_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      clean(1);
    end
    chk("gap_no_pulse", 32'(pulse_seen), 0);
    chk("gap_bit_cnt", 32'(bus.bit_cnt), 40);
    chk("gap_err_cnt", 32'(bus.err_cnt), 0);
    chk("gap_locked", 32'(bus.locked), 1);
    bad();
    chk("gap_err_pulse", 32'(bus.err_pulse), 1);
    step(~bus.bit_in, 1'b0, 1'b0);
    chk("gap_pulse_cleared", 32'(bus.err_pulse), 0);
    chk("gap_hold_err", 32'(bus.err_cnt), 1);
    chk("gap_hold_bit", 32'(bus.bit_cnt), 41);
    gen(b);
    step(~b, 1'b1, 1'b1);
    chk("clr_err_cnt", 32'(bus.err_cnt), 0);
    chk("clr_bit_cnt", 32'(bus.bit_cnt), 0);
    chk("clr_pulse", 32'(bus.err_pulse), 1);
    chk("clr_locked", 32'(bus.locked), 1);
    clean(5);
    chk("clr_then_bits", 32'(bus.bit_cnt), 5);
    #3;
    _rst = 1'b0;
    #1;
    chk("arst_locked", 32'(bus.locked), 0);
    chk("arst_pulse", 32'(bus.err_pulse), 0);
    chk("arst_err", 32'(bus.err_cnt), 0);
    chk("arst_bit", 32'(bus.bit_cnt), 0);
    do_reset();
    clean(48);
    chk("arst_relock", 32'(bus.locked), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_chk.md
# lfsr_chk

Serial PRBS checker for the 16-bit pseudorandom bit streams produced by the lab's LFSR generators. It consumes one bit per valid cycle and self-synchronises to the stream by seeding its history from received bits. Once locked, it predicts each bit from its own recurrence and counts mismatches. It sits at the receiving end of the test link and reports lock status and error statistics.

## Interface
- SYNC_LEN, 32: consecutive correct predictions required to declare lock.
- WIN, 64: loss-detection window length, in valid bits while locked.
- LOSS_THR, 8: errors within one window that cause loss of lock.
- CNT_W, 16: width of the error and bit counters.
- clk  input  1  clock, rising edge.
- _rst  input  1  reset, asynchronous, active-low.
- bit_in  input  1  received serial bit.
- bit_vld  input  1  bit_in is valid this cycle; no state changes when low.
- clr  input  1  synchronous clear of err_cnt and bit_cnt.
- locked  output  1  checker is synchronised.
- err_pulse  output  1  one-cycle flag: last valid bit mismatched while locked.
- err_cnt  output  CNT_W  saturating count of mismatches while locked.
- bit_cnt  output  CNT_W  saturating count of bits compared while locked.

## Operation
- History register h[15:0]:
  - h[0] is the newest bit; h[k] is the bit received k+1 valid bits earlier.
  - Shift rule on a valid bit: h <= {h[14:0], b}.
- Prediction: p = h[15]^h[13]^h[12]^h[10].
  - This is the recurrence s[n] = s[n-16]^s[n-14]^s[n-13]^s[n-11].
  - Characteristic polynomial x^16+x^5+x^3+x^2+1 (maximal length, period 65535).
- States: FILL, VERIFY, LOCKED.
- FILL:
  - Shift bit_in into h; increment fill count (0..16).
  - At fill count ≥16 with h ≠ 0, go to VERIFY.
  - An all-zero h keeps the block in FILL; it never locks on a zero stream.
- VERIFY:
  - Compare bit_in with p and shift bit_in into h.
  - Match: increment the match count. On reaching SYNC_LEN, go to LOCKED.
  - Mismatch: clear the fill and match counts, clear h, go to FILL.
  - err_cnt and bit_cnt are not affected.
- LOCKED:
  - Compare bit_in with p; shift p (not bit_in) into h, so a single channel error yields exactly one counted error.
  - bit_cnt +1 on every compare.
  - On a mismatch: err_cnt +1 and err_pulse for one cycle.
  - Both counters saturate at 2^CNT_W-1.
- Loss detection (see Configuration):
  - Window position wpos (0..WIN-1) and window error count werr advance on valid bits in LOCKED.
  - If werr including the current error reaches LOSS_THR: go to FILL, clear h and the sync counters, drop locked.
  - Otherwise, at wpos = WIN-1, clear wpos and werr.
  - Entering LOCKED clears wpos and werr.
- clr:
  - Sets err_cnt and bit_cnt to 0 and has priority over a same-cycle increment.
  - Does not affect the state or h.
- Reset: state FILL, h = 0, all counters 0, and locked, err_pulse, err_cnt and bit_cnt all 0.

## Timing
- All outputs are registered, with no combinational path from input to output.
- locked rises on the edge that samples the SYNC_LEN-th consecutive match.
  - Clean stream from reset: locked is high after valid bit 16+SYNC_LEN = 48.
- err_pulse is high for exactly the one cycle following the edge that sampled the bad bit.
- err_cnt updates on that same edge.
- locked falls on the edge that samples the LOSS_THR-th window error; that error is still counted in err_cnt.
- bit_vld low:
  - All state and counters hold.
  - err_pulse is 0 on the following cycle.
- Reset asserted mid-operation clears everything immediately; operation restarts in FILL after release.

## Configuration
- LFSR_CHK_LOSS_EN defined:
  - Window loss detection is compiled in.
  - LOCKED returns to FILL as specified.
- Not defined:
  - The wpos and werr logic is absent.
  - LOCKED is left only by reset; errors are still counted and flagged.

## Test plan
- Reset, then a clean recurrence stream seeded with 16'h0001 → locked=1 after valid bit 48; err_cnt=0, bit_cnt increments per bit.
- Locked; flip one bit at compare 100 → one err_pulse; err_cnt=1; no further errors over the next 500 bits.
- 200 zero bits → locked never asserts; state stays FILL.
- Clean fill, then a flipped bit at VERIFY compare 10 → return to FILL; lock only after a further 48 clean valid bits.
- Locked; 8 errors within one 64-bit window:
  - With LFSR_CHK_LOSS_EN: locked=0 after the 8th error; err_cnt=8.
  - Without LFSR_CHK_LOSS_EN: locked=1; err_cnt=8.
- Locked; bit_vld toggled randomly, clr and an error in the same cycle, then _rst low mid-stream:
  - Gaps change nothing.
  - err_cnt=0 after the clr.
  - All outputs are 0 during reset.
